// File: rtl/str_fifo_if.sv
// Stream FIFO bus interface.
// Groups both stream ports of the FIFO plus its occupancy output.
//   slave  : FIFO side (accepts on s_*, presents on m_*, drives count)
//   master : environment side (drives s_* words, consumes m_* words)
// Signals:
//   s_tvalid/s_tready/s_tdata  upstream word handshake into the FIFO
//   m_tvalid/m_tready/m_tdata  head-word handshake out of the FIFO
//   count                      number of stored words, 0..DEPTH
interface str_fifo_if #(
    parameter int VW    = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          s_tvalid;
    logic          s_tready;
    logic [VW-1:0] s_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [VW-1:0] m_tdata;
    logic [CW-1:0] count;

    modport slave (
        input  s_tvalid, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tdata, count
    );

    modport master (
        output s_tvalid, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tdata, count
    );
endinterface

// File: rtl/str_fifo.sv
// Valid/ready stream FIFO, first-word-fall-through, single clock domain.
// Ports:
//   clk  : system clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : str_fifo_if.slave (sink s_*, source m_*, occupancy count)
// The head word is read combinationally from the array, so it is visible
// on m_tdata whenever the FIFO holds at least one word. There is no
// empty bypass and no full passthrough.
module str_fifo #(
    parameter int VW    = 32,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    str_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Array contents are intentionally not reset.
    logic [VW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic s_rdy;
    logic m_vld;
    logic push;
    logic pop;

    always_comb begin
        // Gating ready with rst keeps any push from landing while reset is low.
        s_rdy = rst & (cnt_q != CW'(DEPTH));
        m_vld = (cnt_q != '0);
        push  = bus.s_tvalid & s_rdy;
        pop   = m_vld & bus.m_tready;

        // Pointers wrap by natural overflow since DEPTH is a power of two.
        wp_d  = push ? wp_q + AW'(1) : wp_q;
        rp_d  = pop  ? rp_q + AW'(1) : rp_q;

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= bus.s_tdata;
        end
    end

    assign bus.s_tready = s_rdy;
    assign bus.m_tvalid = m_vld;
    assign bus.m_tdata  = mem_q[rp_q];
    assign bus.count    = cnt_q;
endmodule

// File: tb/tb_str_fifo.sv
// Self-checking bench for str_fifo: queue-based reference model compared
// against the DUT on every falling edge, plus directed literal checks.
module tb_str_fifo;
    localparam int VW    = 32;
    localparam int DEPTH = 8;
    localparam int NWRAP = 3 * DEPTH + 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    str_fifo_if #(.VW(VW), .DEPTH(DEPTH)) bus ();

    str_fifo #(.VW(VW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of the words currently held.
    logic [VW-1:0] mq [$];

    always @(posedge clk or negedge rst) begin
        bit pu;
        bit po;
        if (!rst) begin
            mq.delete();
        end else begin
            pu = bus.s_tvalid && (mq.size() < DEPTH);
            po = bus.m_tready && (mq.size() > 0);
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(bus.s_tdata);
        end
    end

    always @(negedge clk) begin
        chk("model_count", 32'(bus.count), 32'(mq.size()));
        chk("model_m_tvalid", 32'(bus.m_tvalid), 32'(mq.size() != 0));
        chk("model_s_tready", 32'(bus.s_tready), 32'(rst && (mq.size() < DEPTH)));
        if (mq.size() != 0) chk("model_m_tdata", bus.m_tdata, mq[0]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pushed;
        int popped;
        int cyc;
        logic [31:0] nd;
        logic [31:0] exp_next;
        bit do_push;

        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.m_tready = 1'b0;
        #1 rst = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            bus.s_tvalid = 1'($urandom_range(0, 1));
            bus.m_tready = 1'($urandom_range(0, 1));
            bus.s_tdata  = $urandom;
            step();
            chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
            chk("rst_s_tready", 32'(bus.s_tready), 32'd0);
            chk("rst_count", 32'(bus.count), 32'd0);
        end
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rel_s_tready", 32'(bus.s_tready), 32'd1);
        step();
        chk("rel_m_tvalid", 32'(bus.m_tvalid), 32'd0);

        // Fill to full
        for (int i = 1; i <= DEPTH; i++) begin
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = 32'(i);
            step();
            chk("fill_count", 32'(bus.count), 32'(i));
        end
        chk("full_s_tready", 32'(bus.s_tready), 32'd0);
        bus.s_tdata = 32'h9;
        repeat (3) step();
        chk("held_count", 32'(bus.count), 32'd8);
        chk("held_head", bus.m_tdata, 32'h1);

        // Drain from full
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_data", bus.m_tdata, 32'(i));
            chk("drain_m_tvalid", 32'(bus.m_tvalid), 32'd1);
            step();
            if (i == 1) chk("drain_s_tready", 32'(bus.s_tready), 32'd1);
        end
        chk("empty_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("empty_count", 32'(bus.count), 32'd0);
        bus.m_tready = 1'b0;

        // Simultaneous push/pop at count 4
        for (int i = 0; i < 4; i++) begin
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = 32'(200 + i);
            step();
        end
        chk("sim_start_count", 32'(bus.count), 32'd4);
        bus.m_tready = 1'b1;
        for (int i = 4; i < 24; i++) begin
            chk("sim_order", bus.m_tdata, 32'(200 + i - 4));
            bus.s_tdata = 32'(200 + i);
            step();
            chk("sim_count", 32'(bus.count), 32'd4);
        end
        bus.s_tvalid = 1'b0;
        repeat (4) step();
        bus.m_tready = 1'b0;
        chk("sim_end_count", 32'(bus.count), 32'd0);

        // Wrap-around with random backpressure on both sides
        pushed   = 0;
        popped   = 0;
        cyc      = 0;
        nd       = 32'd1000;
        exp_next = 32'd1000;
        bus.s_tdata = nd;
        while (popped < NWRAP && cyc < 3000) begin
            bus.s_tvalid = (pushed < NWRAP) && ($urandom_range(0, 1) == 1);
            bus.m_tready = 1'($urandom_range(0, 1));
            #1;
            do_push = bus.s_tvalid && bus.s_tready;
            if (bus.m_tvalid && bus.m_tready) begin
                chk("wrap_order", bus.m_tdata, exp_next);
                exp_next++;
                popped++;
            end
            step();
            if (do_push) begin
                pushed++;
                nd++;
                bus.s_tdata = nd;
            end
            cyc++;
        end
        if (popped < NWRAP) chk("wrap_timeout", 32'(popped), 32'(NWRAP));
        chk("wrap_pushed", 32'(pushed), 32'(NWRAP));
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b0;
        step();
        chk("wrap_end_count", 32'(bus.count), 32'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) begin
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = 32'(300 + i);
            step();
        end
        bus.s_tvalid = 1'b0;
        chk("mid_pre_count", 32'(bus.count), 32'd5);
        #2 rst = 1'b0;
        #1;
        chk("mid_count", 32'(bus.count), 32'd0);
        chk("mid_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("mid_s_tready", 32'(bus.s_tready), 32'd0);
        #3 rst = 1'b1;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = 32'hA5A5_A5A5;
        step();
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b1;
        chk("post_m_tvalid", 32'(bus.m_tvalid), 32'd1);
        chk("post_first_word", bus.m_tdata, 32'hA5A5_A5A5);
        step();
        chk("post_count", 32'(bus.count), 32'd0);
        bus.m_tready = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/str_fifo.md
# str_fifo

Synthesizable valid/ready stream FIFO: sink port accepts words from an upstream stream source, source port presents them in order to a downstream stream drain. It gives the RTL side of the stream interface that the testbench source and drain models drive and consume, and provides elastic buffering between two stream stages in one clock domain. First-word-fall-through: the head word is visible on the source port whenever the FIFO is non-empty.

## Interface

Parameters:
- VW, 32, data width in bits
- DEPTH, 8, storage depth in words; power of two, at least 2
- CW, $clog2(DEPTH)+1, count width; derived, not overridden

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset; one clock, reset is asynchronous and active-low
- s_tvalid  input  1  sink: upstream word valid
- s_tready  output  1  sink: FIFO can accept a word
- s_tdata  input  VW  sink: upstream word
- m_tvalid  output  1  source: head word valid
- m_tready  input  1  source: downstream accepts head word
- m_tdata  output  VW  source: head word
- count  output  CW  number of stored words, 0..DEPTH

## Operation

- Storage: DEPTH x VW array, write pointer wp, read pointer rp, each $clog2(DEPTH) bits, plus occupancy cnt (CW bits).
- Push = s_tvalid & s_tready. On push, mem[wp] <= s_tdata, wp <= wp+1.
- Pop = m_tvalid & m_tready. On pop, rp <= rp+1.
- Pointers wrap modulo DEPTH by natural overflow; no explicit compare against DEPTH-1.
- cnt <= cnt + push - pop. Push and pop in the same cycle leave cnt unchanged.
- s_tready = rst & (cnt != DEPTH). Full blocks push even if a pop happens in the same cycle; there is no full-state passthrough.
- m_tvalid = (cnt != 0). Empty blocks pop; there is no empty-state bypass. A word is never presented in the cycle it is written.
- m_tdata = mem[rp], read combinationally from the array.
- count = cnt.
- Stream rules honoured on the source port: once m_tvalid is high it stays high, and m_tdata stays stable, until a pop. m_tvalid does not depend combinationally on m_tready.
- Sink port: the FIFO does not depend on upstream holding s_tdata stable. Any cycle with s_tvalid & s_tready is a transfer.
- Array contents are not reset. m_tdata is don't-care while m_tvalid is low.

## Timing

- Reset (rst low, asynchronous assert):
  - wp = rp = 0, cnt = 0.
  - count = 0, m_tvalid = 0, s_tready = 0.
- After rst deasserts: s_tready = 1 from the first cycle after rst is sampled high.
- Reset mid-operation discards all stored words immediately. No pop or push completes in a cycle in which rst is low.
- Latency: a word pushed at edge k gives m_tvalid high after edge k, and can be popped at edge k+1 at the earliest. Minimum sink-to-source latency is 1 cycle.
- Throughput: 1 word per cycle in steady state when neither full nor empty with both sides ready.
- Full: cnt = DEPTH gives s_tready = 0 after the filling edge. A pop at edge j gives s_tready = 1 after edge j.
- Empty: the last pop at edge j gives m_tvalid = 0 after edge j.
- Ordering: strictly first-in first-out across any number of pointer wraps.

## Test plan

- Reset values: hold rst low with random s_tvalid/m_tready.
  - Required: m_tvalid = 0, s_tready = 0, count = 0.
  - After release: s_tready = 1 within 1 cycle, m_tvalid = 0.
- Fill (DEPTH = 8, m_tready = 0): push 0x00000001..0x00000008 back-to-back.
  - Required: count steps 1..8 and s_tready = 0 after the 8th push.
  - A 9th word 0x00000009 is held off; count stays 8, and 0x9 is not accepted until after a pop.
- Drain: from full, set m_tready = 1.
  - Required: m_tdata sequence 0x1..0x8 on consecutive cycles.
  - m_tvalid falls after the 8th pop; count reaches 0.
  - s_tready rises after the first pop.
- Simultaneous push/pop: at count = 4, s_tvalid = m_tready = 1 for 20 cycles.
  - Required: count stays 4 throughout; output order matches input order.
- Wrap-around and backpressure: 3*DEPTH+5 incrementing words, random s_tvalid and m_tready at 50%.
  - Required: scoreboard shows all words in order, none lost or duplicated.
  - m_tdata is stable whenever m_tvalid & !m_tready.
  - count always equals pushes minus pops, within 0..8.
- Reset mid-operation: at count = 5, pulse rst low asynchronously between edges.
  - Required: count = 0 and m_tvalid = 0 immediately.
  - After release, push 0xA5A5A5A5; it is the first word popped.
